fifo_wr_ctrl: RTL

//  Parametrised write-side controller of the async FIFO; next generation of the fixed 8-deep write block.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_gray2bin.sv | 14 +
 rtl/fifo_wr_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO controllers: Gray/binary conversion
// and pointer/counter width constants.
package fifo_pkg;

    localparam int OVF_CNT_W = 8;

    function automatic int ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

    // Width-generic: callers zero-extend into 32 bits and cast the result back down.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Parametrised Gray-to-binary decoder; each binary bit is the XOR of all Gray bits
// at or above it. Shared by the write- and read-side controllers.
module fifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: binary address, registered Gray pointer,
// full/almost-full, fill level and sticky overflow. Macro FIFO_WR_OVF_CNT_EN adds W_OVF_CNT.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter  int ADDR_WIDTH = 3,
    localparam int PTR_W      = ptr_w(ADDR_WIDTH)
) (
    input  logic                 W_CLK,
    input  logic                 W_RST,
    input  logic                 W_INC,
    input  logic [PTR_W-1:0]     R_PTR_SYNC,
    input  logic [PTR_W-1:0]     W_AFULL_THR,
    input  logic                 W_OVF_CLR,
    output logic [PTR_W-1:0]     W_ADDR,
    output logic [PTR_W-1:0]     W_PTR,
    output logic                 W_FULL,
    output logic                 W_AFULL,
    output logic [PTR_W-1:0]     W_LEVEL,
    output logic                 W_OVF
`ifdef FIFO_WR_OVF_CNT_EN
    ,
    output logic [OVF_CNT_W-1:0] W_OVF_CNT
`endif
);

    logic [PTR_W-1:0] w_addr_q, w_addr_d;
    logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
    logic             w_ovf_q, w_ovf_d;
    logic [PTR_W-1:0] r_bin_s;
    logic             full_s;
    logic             wr_acc_s;
    logic             wr_drop_s;

    fifo_gray2bin #(.W(PTR_W)) u_rptr_dec (
        .gray_i (R_PTR_SYNC),
        .bin_o  (r_bin_s)
    );

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_s    = (w_ptr_q[PTR_W-1:PTR_W-2] == ~R_PTR_SYNC[PTR_W-1:PTR_W-2]) &&
                       (w_ptr_q[PTR_W-3:0] == R_PTR_SYNC[PTR_W-3:0]);
    assign wr_acc_s  = W_INC & ~full_s;
    assign wr_drop_s = W_INC & full_s;

    // Next-state: pointer advance and sticky overflow (set beats clear).
    always_comb begin
        w_addr_d = w_addr_q;
        w_ovf_d  = w_ovf_q;
        if (wr_acc_s) begin
            w_addr_d = w_addr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            w_addr_d = w_addr_q;
        end
        if (wr_drop_s) begin
            w_ovf_d = 1'b1;
        end else if (W_OVF_CLR) begin
            w_ovf_d = 1'b0;
        end else begin
            w_ovf_d = w_ovf_q;
        end
        w_ptr_d = PTR_W'(bin2gray(32'(w_addr_d)));
    end

    // State registers; Gray pointer is registered so the synchroniser never sees comb glitches.
    always_ff @(posedge W_CLK or posedge W_RST) begin
        if (W_RST) begin
            w_addr_q <= {PTR_W{1'b0}};
            w_ptr_q  <= {PTR_W{1'b0}};
            w_ovf_q  <= 1'b0;
        end else begin
            w_addr_q <= w_addr_d;
            w_ptr_q  <= w_ptr_d;
            w_ovf_q  <= w_ovf_d;
        end
    end

`ifdef FIFO_WR_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d, ovf_base_s;

    // Dropped-write counter: clear then increment, so a concurrent drop leaves 1.
    always_comb begin
        if (W_OVF_CLR) begin
            ovf_base_s = {OVF_CNT_W{1'b0}};
        end else begin
            ovf_base_s = ovf_cnt_q;
        end
        if (wr_drop_s && (ovf_base_s != {OVF_CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_base_s + {{(OVF_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ovf_cnt_d = ovf_base_s;
        end
    end

    // Counter register.
    always_ff @(posedge W_CLK or posedge W_RST) begin
        if (W_RST) begin
            ovf_cnt_q <= {OVF_CNT_W{1'b0}};
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign W_OVF_CNT = ovf_cnt_q;
`endif

    assign W_ADDR  = w_addr_q;
    assign W_PTR   = w_ptr_q;
    assign W_FULL  = full_s;
    assign W_LEVEL = w_addr_q - r_bin_s;
    assign W_AFULL = (W_LEVEL >= W_AFULL_THR);
    assign W_OVF   = w_ovf_q;

endmodule
